// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for the word-addressed data_mem.
// Sub-word loads are extended here; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_ReqValid,
    output logic                      o_ReqReady,
    input  logic                      i_ReqWe,
    input  logic [2:0]                i_Funct3,
    input  logic [31:0]               i_Addr,
    input  logic [DATA_WIDTH-1:0]     i_StoreData,
    output logic                      o_RspValid,
    output logic [DATA_WIDTH-1:0]     o_LoadData,
    output logic                      o_Misaligned,
    output logic                      o_Illegal,
    output logic [MEM_ADDR_WIDTH-1:0] o_MemAddr,
    output logic [DATA_WIDTH-1:0]     o_MemDataOut,
    output logic                      o_MemWrEn,
    input  logic [DATA_WIDTH-1:0]     i_MemDataIn
);

    typedef enum logic [2:0] {
        IDLE, LOAD, MERGE, WRITE, RESP
    } state_t;

    state_t state, state_nxt;

    logic [31:0]           addr_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [DATA_WIDTH-1:0] wbuf;
    logic [DATA_WIDTH-1:0] load_q;
    logic                  mis_q;
    logic                  ill_q;

    logic                  accept;
    logic                  req_ill;
    logic                  req_mis;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] merged;
    logic                  unused_bits;

    assign accept = i_ReqValid && (state == IDLE);

    // Only the word-address bits and nothing else of the latched request
    // beyond what the FSM needs are consumed downstream.
    assign unused_bits = ^{addr_q[31:MEM_ADDR_WIDTH+2], we_q};

    // Classify the incoming request; illegal takes precedence over misaligned.
    always_comb begin
        if (i_ReqWe) begin
            req_ill = !(i_Funct3 == 3'b000 ||
                        i_Funct3 == 3'b001 ||
                        i_Funct3 == 3'b010);
        end else begin
            req_ill = (i_Funct3 == 3'b011) ||
                      (i_Funct3[2:1] == 2'b11);
        end
        req_mis = !req_ill &&
                  ((i_Funct3[1:0] == 2'b01 && i_Addr[0]) ||
                   (i_Funct3[1:0] == 2'b10 && i_Addr[1:0] != 2'b00));
    end

    // Lane select and sign/zero extension for loads.
    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    byte_v = i_MemDataIn[7:0];
            2'd1:    byte_v = i_MemDataIn[15:8];
            2'd2:    byte_v = i_MemDataIn[23:16];
            default: byte_v = i_MemDataIn[31:24];
        endcase
        half_v = addr_q[1] ? i_MemDataIn[31:16] : i_MemDataIn[15:0];
        unique case (f3_q)
            3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_val = {{16{half_v[15]}}, half_v};
            3'b100:  load_val = {24'd0, byte_v};
            3'b101:  load_val = {16'd0, half_v};
            default: load_val = i_MemDataIn;
        endcase
    end

    // Overlay the store byte/halfword onto the current memory word.
    always_comb begin
        merged = i_MemDataIn;
        if (f3_q[0]) begin
            if (addr_q[1]) merged[31:16] = wbuf[15:0];
            else           merged[15:0]  = wbuf[15:0];
        end else begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wbuf[7:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; the route is decided from the request at accept.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_ill || req_mis)     state_nxt = RESP;
                    else if (!i_ReqWe)          state_nxt = LOAD;
                    else if (i_Funct3 == 3'b010) state_nxt = WRITE;
                    else                        state_nxt = MERGE;
                end
            end
            LOAD:    state_nxt = RESP;
            MERGE:   state_nxt = WRITE;
            WRITE:   state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latches, write buffer and registered load result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            we_q   <= 1'b0;
            f3_q   <= '0;
            wbuf   <= '0;
            load_q <= '0;
            mis_q  <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= i_Addr;
                we_q   <= i_ReqWe;
                f3_q   <= i_Funct3;
                wbuf   <= i_StoreData;
                load_q <= '0;
                mis_q  <= req_mis;
                ill_q  <= req_ill;
            end
            if (state == LOAD)  load_q <= load_val;
            if (state == MERGE) wbuf   <= merged;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        o_ReqReady   = (state == IDLE);
        o_RspValid   = (state == RESP);
        o_MemWrEn    = (state == WRITE);
        o_MemDataOut = (state == WRITE) ? wbuf : '0;
        o_Misaligned = (state == RESP) && mis_q;
        o_Illegal    = (state == RESP) && ill_q;
        o_LoadData   = load_q;
        o_MemAddr    = addr_q[MEM_ADDR_WIDTH+1:2];
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
// Requests are driven on the falling edge; outputs are sampled there too.
module tb_load_store_unit;

    localparam int AW = 10;

    logic          clk;
    logic          reset;
    logic          i_ReqValid;
    logic          o_ReqReady;
    logic          i_ReqWe;
    logic [2:0]    i_Funct3;
    logic [31:0]   i_Addr;
    logic [31:0]   i_StoreData;
    logic          o_RspValid;
    logic [31:0]   o_LoadData;
    logic          o_Misaligned;
    logic          o_Illegal;
    logic [AW-1:0] o_MemAddr;
    logic [31:0]   o_MemDataOut;
    logic          o_MemWrEn;
    logic [31:0]   i_MemDataIn;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:(1<<AW)-1] = '{default: 32'd0};
    int          wr_cnt = 0;
    logic [31:0] last_wa = 0;
    logic [31:0] last_wd = 0;

    int          r_lat;
    int          r_wr;
    logic [31:0] r_ld;
    logic [31:0] r_ld_hold;
    logic        r_mis;
    logic        r_ill;
    logic        r_flags_after;

    load_store_unit #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .i_ReqValid(i_ReqValid), .o_ReqReady(o_ReqReady),
        .i_ReqWe(i_ReqWe), .i_Funct3(i_Funct3),
        .i_Addr(i_Addr), .i_StoreData(i_StoreData),
        .o_RspValid(o_RspValid), .o_LoadData(o_LoadData),
        .o_Misaligned(o_Misaligned), .o_Illegal(o_Illegal),
        .o_MemAddr(o_MemAddr), .o_MemDataOut(o_MemDataOut),
        .o_MemWrEn(o_MemWrEn), .i_MemDataIn(i_MemDataIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_MemDataIn = mem[o_MemAddr];

    always @(posedge clk) begin
        if (o_MemWrEn) begin
            mem[o_MemAddr] <= o_MemDataOut;
            last_wa <= 32'(o_MemAddr);
            last_wd <= o_MemDataOut;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
        int wr0;
        int n;
        @(negedge clk);
        n = 0;
        while (!o_ReqReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        i_ReqValid = 1'b1;
        i_ReqWe = we;
        i_Funct3 = f3;
        i_Addr = a;
        i_StoreData = sd;
        wr0 = wr_cnt;
        @(negedge clk);
        i_ReqValid = 1'b0;
        r_lat = 1;
        while (!o_RspValid && r_lat < 10) begin
            @(negedge clk);
            r_lat++;
        end
        if (!o_RspValid) r_lat = -1;
        r_ld = o_LoadData;
        r_mis = o_Misaligned;
        r_ill = o_Illegal;
        r_wr = wr_cnt - wr0;
        @(negedge clk);
        r_ld_hold = o_LoadData;
        r_flags_after = o_Misaligned | o_Illegal | o_RspValid;
    endtask

    initial begin : stim
        int acc;
        int rsp;
        int bad;
        int wr0;
        int rsp_seen;
        logic just_acc;
        logic [31:0] got [0:3];

        reset = 1'b0;
        i_ReqValid = 1'b0;
        i_ReqWe = 1'b0;
        i_Funct3 = 3'b000;
        i_Addr = 32'd0;
        i_StoreData = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(o_ReqReady), 32'd1);
        chk("rst_rsp", 32'(o_RspValid), 32'd0);
        chk("rst_ld", o_LoadData, 32'd0);
        chk("rst_we", 32'(o_MemWrEn), 32'd0);
        chk("rst_addr", 32'(o_MemAddr), 32'd0);
        chk("rst_wdata", o_MemDataOut, 32'd0);
        chk("rst_flags", 32'({o_Misaligned, o_Illegal}), 32'd0);
        reset = 1'b1;

        xact(1'b1, 3'b010, 32'h10, 32'h8899AABB);
        chk("sw_lat", 32'(r_lat), 32'd2);
        chk("sw_writes", 32'(r_wr), 32'd1);
        chk("sw_waddr", last_wa, 32'd4);
        chk("sw_wdata", last_wd, 32'h8899AABB);
        chk("sw_ld", r_ld, 32'd0);
        chk("sw_flags", 32'({r_mis, r_ill}), 32'd0);

        xact(1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_lat", 32'(r_lat), 32'd2);
        chk("lw_data", r_ld, 32'h8899AABB);
        chk("lw_hold", r_ld_hold, 32'h8899AABB);
        chk("lw_writes", 32'(r_wr), 32'd0);

        xact(1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb_13", r_ld, 32'hFFFFFF88);
        xact(1'b0, 3'b100, 32'h11, 32'h0);
        chk("lbu_11", r_ld, 32'h000000AA);
        xact(1'b0, 3'b001, 32'h12, 32'h0);
        chk("lh_12", r_ld, 32'hFFFF8899);
        xact(1'b0, 3'b101, 32'h10, 32'h0);
        chk("lhu_10", r_ld, 32'h0000AABB);

        xact(1'b1, 3'b000, 32'h11, 32'hFFFFFF55);
        chk("sb_lat", 32'(r_lat), 32'd3);
        chk("sb_writes", 32'(r_wr), 32'd1);
        xact(1'b0, 3'b010, 32'h10, 32'h0);
        chk("sb_readback", r_ld, 32'h889955BB);

        xact(1'b1, 3'b001, 32'h12, 32'h1234BEEF);
        chk("sh_lat", 32'(r_lat), 32'd3);
        chk("sh_writes", 32'(r_wr), 32'd1);
        xact(1'b0, 3'b001, 32'h12, 32'h0);
        chk("sh_lh_back", r_ld, 32'hFFFFBEEF);
        xact(1'b0, 3'b010, 32'h10, 32'h0);
        chk("sh_readback", r_ld, 32'hBEEF55BB);

        xact(1'b0, 3'b010, 32'h12, 32'h0);
        chk("lw_mis_lat", 32'(r_lat), 32'd1);
        chk("lw_mis_flag", 32'(r_mis), 32'd1);
        chk("lw_mis_ill", 32'(r_ill), 32'd0);
        chk("lw_mis_ld", r_ld, 32'd0);
        chk("flags_after", 32'(r_flags_after), 32'd0);

        xact(1'b1, 3'b001, 32'h11, 32'h0000CAFE);
        chk("sh_mis_flag", 32'(r_mis), 32'd1);
        chk("sh_mis_wr", 32'(r_wr), 32'd0);

        xact(1'b0, 3'b011, 32'h10, 32'h0);
        chk("ld_ill_flag", 32'(r_ill), 32'd1);
        chk("ld_ill_mis", 32'(r_mis), 32'd0);
        chk("ld_ill_lat", 32'(r_lat), 32'd1);

        xact(1'b1, 3'b101, 32'h11, 32'h0);
        chk("both_flags", 32'({r_mis, r_ill}), 32'd1);
        chk("both_wr", 32'(r_wr), 32'd0);
        chk("mem_intact", mem[4], 32'hBEEF55BB);

        xact(1'b1, 3'b010, 32'h14, 32'h11111111);
        xact(1'b1, 3'b010, 32'h18, 32'h22222222);

        acc = 0;
        rsp = 0;
        bad = 0;
        just_acc = 1'b0;
        @(negedge clk);
        i_ReqWe = 1'b0;
        i_Funct3 = 3'b010;
        i_Addr = 32'h14;
        i_ReqValid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (just_acc) begin
                just_acc = 1'b0;
                if (acc == 1) i_Addr = 32'h18;
                else          i_ReqValid = 1'b0;
            end
            if (o_RspValid) begin
                if (o_ReqReady) bad++;
                if (rsp < 4) got[rsp] = o_LoadData;
                rsp++;
            end
            if (i_ReqValid && o_ReqReady) begin
                acc++;
                just_acc = 1'b1;
            end
            @(negedge clk);
        end
        chk("hs_accepts", 32'(acc), 32'd2);
        chk("hs_responses", 32'(rsp), 32'd2);
        chk("hs_ready_in_resp", 32'(bad), 32'd0);
        chk("hs_data0", got[0], 32'h11111111);
        chk("hs_data1", got[1], 32'h22222222);

        @(negedge clk);
        i_ReqValid = 1'b1;
        i_ReqWe = 1'b1;
        i_Funct3 = 3'b001;
        i_Addr = 32'h10;
        i_StoreData = 32'h00001234;
        wr0 = wr_cnt;
        @(negedge clk);
        i_ReqValid = 1'b0;
        chk("rm_in_merge", 32'(o_ReqReady), 32'd0);
        reset = 1'b0;
        rsp_seen = 0;
        #1;
        chk("rm_ready_now", 32'(o_ReqReady), 32'd1);
        repeat (3) begin
            @(negedge clk);
            if (o_RspValid) rsp_seen++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (o_RspValid) rsp_seen++;
        end
        chk("rm_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("rm_no_rsp", 32'(rsp_seen), 32'd0);
        chk("rm_ready", 32'(o_ReqReady), 32'd1);
        chk("rm_mem", mem[4], 32'hBEEF55BB);
        xact(1'b0, 3'b010, 32'h10, 32'h0);
        chk("rm_readback", r_ld, 32'hBEEF55BB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
